// File: rtl/tick_pkg.sv
// Shared constants, divisor word type and divisor clamping for the tick generator.
package tick_pkg;

  localparam int CNT_W_DEF   = 27;
  localparam int DIV_RST_DEF = 100000;

  typedef logic [CNT_W_DEF-1:0] div_t;

  // A divisor of 0 runs the same as a divisor of 1: a tick every enabled cycle.
  function automatic logic [31:0] clamp_div(input logic [31:0] d);
    return (d == 32'd0) ? 32'd1 : d;
  endfunction

endpackage

// File: rtl/tick_channel.sv
// One tick channel: divide counter, shadow/active divisor, tick pulse and square enable.
module tick_channel
  import tick_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DIV_RST = DIV_RST_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync_clr,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_val,
  output logic             tick,
  output logic             sq,
  output logic             busy,
  output logic             fire
);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] act_div;
  logic [CNT_W-1:0] shadow;
  logic [CNT_W-1:0] last;

  // CNT_W is limited to 32 bits by the clamp helper.
  assign last = CNT_W'(clamp_div(32'(act_div)) - 32'd1);

  // Terminal count this cycle; feeds the tick register here and the scan counter at top.
  assign fire = en && !sync_clr && (count == last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      act_div <= CNT_W'(DIV_RST);
      shadow  <= CNT_W'(DIV_RST);
      tick    <= 1'b0;
      sq      <= 1'b0;
      busy    <= 1'b0;
    end else if (sync_clr) begin
      count   <= '0;
      sq      <= 1'b0;
      tick    <= 1'b0;
      act_div <= shadow;
      busy    <= 1'b0;
    end else begin
      tick <= fire;
      if (en) begin
        if (fire) begin
          count   <= '0;
          sq      <= ~sq;
          act_div <= shadow;
          busy    <= 1'b0;
        end else begin
          count <= count + CNT_W'(1);
        end
      end
      // A write coinciding with a terminal count stays pending for the next period.
      if (wr) begin
        shadow <= wr_val;
        busy   <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/multi_tick_gen.sv
// Multi-channel tick generator: divisor write decode, channel array and scan index counter.
module multi_tick_gen
  import tick_pkg::*;
#(
  parameter int N_CH    = 3,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DIV_RST = DIV_RST_DEF,
  parameter int SCAN_W  = 2,
  parameter int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   en,
  input  logic              sync_clr,
  input  logic              div_wr,
  input  logic [CH_W-1:0]   div_ch,
  input  logic [CNT_W-1:0]  div_val,
  output logic [N_CH-1:0]   tick,
  output logic [N_CH-1:0]   sq,
  output logic [SCAN_W-1:0] scan,
  output logic [N_CH-1:0]   div_busy
);

  logic [N_CH-1:0] wr_sel;
  logic [N_CH-1:0] fire;

  // Out-of-range channel numbers select nothing; sync_clr drops the write.
  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < N_CH; i++) begin
      wr_sel[i] = div_wr && !sync_clr && (32'(div_ch) == i);
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    tick_channel #(
      .CNT_W  (CNT_W),
      .DIV_RST(DIV_RST)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en[g]),
      .sync_clr(sync_clr),
      .wr      (wr_sel[g]),
      .wr_val  (div_val),
      .tick    (tick[g]),
      .sq      (sq[g]),
      .busy    (div_busy[g]),
      .fire    (fire[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan <= '0;
    end else if (sync_clr) begin
      scan <= '0;
    end else if (fire[0]) begin
      scan <= scan + SCAN_W'(1);
    end
  end

endmodule

// File: tb/tb_multi_tick_gen.sv
// Self-checking bench for multi_tick_gen with a per-cycle expected-output queue.
module tb_multi_tick_gen;

  localparam int N_CH = 3;
  localparam int CNT_W = 8;
  localparam int DIV_RST = 4;
  localparam int SCAN_W = 2;
  localparam int CH_W = 2;
  localparam int VW = 3 * N_CH + SCAN_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N_CH-1:0]   en = '0;
  logic              sync_clr = 1'b0;
  logic              div_wr = 1'b0;
  logic [CH_W-1:0]   div_ch = '0;
  logic [CNT_W-1:0]  div_val = '0;
  logic [N_CH-1:0]   tick;
  logic [N_CH-1:0]   sq;
  logic [SCAN_W-1:0] scan;
  logic [N_CH-1:0]   div_busy;

  int n_total = 0;
  int n_bad = 0;
  logic [VW-1:0] exp_q[$];

  // reference state
  int m_cnt[N_CH];
  int m_act[N_CH];
  int m_shd[N_CH];
  bit m_busy[N_CH];
  bit m_sq[N_CH];
  bit m_tick[N_CH];
  int m_scan;

  multi_tick_gen #(
    .N_CH(N_CH), .CNT_W(CNT_W), .DIV_RST(DIV_RST), .SCAN_W(SCAN_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sync_clr(sync_clr), .div_wr(div_wr),
    .div_ch(div_ch), .div_val(div_val), .tick(tick), .sq(sq), .scan(scan),
    .div_busy(div_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N_CH; i++) begin
      m_cnt[i] = 0; m_act[i] = DIV_RST; m_shd[i] = DIV_RST;
      m_busy[i] = 0; m_sq[i] = 0; m_tick[i] = 0;
    end
    m_scan = 0;
  endtask

  task automatic model_step();
    int eff;
    if (sync_clr) begin
      for (int i = 0; i < N_CH; i++) begin
        m_cnt[i] = 0; m_sq[i] = 0; m_tick[i] = 0;
        m_act[i] = m_shd[i]; m_busy[i] = 0;
      end
      m_scan = 0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        m_tick[i] = 0;
        if (en[i]) begin
          eff = (m_act[i] < 2) ? 1 : m_act[i];
          if (m_cnt[i] == eff - 1) begin
            m_cnt[i] = 0; m_tick[i] = 1; m_sq[i] = ~m_sq[i];
            m_act[i] = m_shd[i]; m_busy[i] = 0;
          end else begin
            m_cnt[i]++;
          end
        end
        if (div_wr && int'(div_ch) == i) begin
          m_shd[i] = int'(div_val); m_busy[i] = 1;
        end
      end
      if (m_tick[0]) m_scan = (m_scan + 1) % (1 << SCAN_W);
    end
  endtask

  function automatic logic [VW-1:0] model_vec();
    logic [N_CH-1:0] b, s, t;
    for (int i = 0; i < N_CH; i++) begin
      b[i] = m_busy[i]; s[i] = m_sq[i]; t[i] = m_tick[i];
    end
    return {b, SCAN_W'(m_scan), s, t};
  endfunction

  // Inputs are set at the negedge before calling; one clock is taken and outputs compared.
  task automatic cycle(input string tag);
    logic [VW-1:0] e;
    model_step();
    exp_q.push_back(model_vec());
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check(tag, 32'({div_busy, scan, sq, tick}), 32'(e));
    div_wr = 1'b0;
    sync_clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic write_div(input int ch, input int val);
    div_wr = 1'b1; div_ch = CH_W'(ch); div_val = CNT_W'(val);
    cycle("wr");
  endtask

  task automatic wait_cnt(input int ch, input int val);
    int g = 0;
    while (m_cnt[ch] != val && g < 64) begin
      cycle("wait_cnt");
      g++;
    end
    check("wait_cnt_bound", 32'(g < 64), 32'd1);
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((m_busy[0] || m_busy[1] || m_busy[2]) && g < 64) begin
      cycle("wait_idle");
      g++;
    end
    check("wait_idle_bound", 32'(g < 64), 32'd1);
  endtask

  initial begin
    int k;
    model_reset();
    #1;
    check("rst_out", 32'({div_busy, scan, sq, tick}), 32'd0);
    #12;
    rst_n = 1'b1;
    @(negedge clk);
    en = '1;

    // default divisor of 4: ticks on cycles 4, 8, 12, 16
    for (int c = 1; c <= 16; c++) begin
      cycle("dflt");
      check("dflt_tick", 32'(tick), (c % 4 == 0) ? 32'h7 : 32'h0);
      if (c % 4 == 0) check("dflt_scan", 32'(scan), 32'((c / 4) % 4));
    end

    // mid-period divisor change on channel 1
    for (int i = 0; i < N_CH; i++) write_div(i, 10);
    wait_idle();
    wait_cnt(1, 2);
    write_div(1, 3);
    check("busy_set", 32'(div_busy[1]), 32'd1);
    k = 0;
    while (!tick[1] && k < 20) begin
      cycle("mid_wait");
      k++;
    end
    check("mid_first_tick", 32'(k), 32'd7);
    check("mid_busy_clr", 32'(div_busy[1]), 32'd0);
    k = 0;
    do begin
      cycle("mid_next");
      k++;
    end while (!tick[1] && k < 20);
    check("mid_period", 32'(k), 32'd3);

    // enable pause on channel 2
    write_div(2, 8);
    wait_idle();
    wait_cnt(2, 5);
    en = 3'b011;
    for (int c = 0; c < 7; c++) begin
      cycle("pause");
      check("pause_tick", 32'(tick[2]), 32'd0);
    end
    en = 3'b111;
    k = 0;
    do begin
      cycle("resume");
      k++;
    end while (!tick[2] && k < 20);
    check("resume_gap", 32'(k), 32'd3);

    // sync_clr colliding with a write; an older pending shadow is applied
    write_div(1, 6);
    sync_clr = 1'b1; div_wr = 1'b1; div_ch = 2'd0; div_val = 8'd2;
    cycle("clr");
    check("clr_out", 32'({tick, sq, scan, div_busy}), 32'd0);
    for (int c = 0; c < 24; c++) cycle("post_clr");

    // edge divisors and an out-of-range channel
    write_div(0, 0);
    write_div(1, 1);
    wait_idle();
    for (int c = 0; c < 12; c++) cycle("edge_div");
    check("edge_tick", 32'(tick[1:0]), 32'h3);
    div_wr = 1'b1; div_ch = 2'd3; div_val = 8'd9;
    cycle("bad_ch");
    check("bad_ch_busy", 32'(div_busy), 32'd0);
    for (int c = 0; c < 6; c++) cycle("bad_ch_run");

    // randomised traffic
    for (int c = 0; c < 300; c++) begin
      en = N_CH'($urandom_range(0, 7));
      if ($urandom_range(0, 5) == 0) begin
        div_wr = 1'b1;
        div_ch = CH_W'($urandom_range(0, 3));
        div_val = CNT_W'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 40) == 0) sync_clr = 1'b1;
      cycle("rand");
    end

    // asynchronous reset between clock edges
    en = '1;
    write_div(2, 7);
    for (int c = 0; c < 5; c++) cycle("pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", 32'({div_busy, scan, sq, tick}), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      cycle("post_rst");
      check("post_rst_tick", 32'(tick), (c % 4 == 0) ? 32'h7 : 32'h0);
    end

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/multi_tick_gen.md
Name: multi_tick_gen

Overview:
- Parametrised multi-channel tick generator.
- Each channel has a runtime-programmable divisor and produces a single-cycle tick enable plus a 50%-duty square enable.
- Channel 0 also drives a free-running scan index for seven-segment digit multiplexing.
- Sits at the top level and feeds display refresh, floor-travel timing and door-open timers. All consumers stay on `clk` and use the ticks as clock enables, never as derived clocks.

Parameters:
- N_CH, 3, number of independent channels (1..8).
- CNT_W, 27, width of each channel's divide counter and divisor.
- DIV_RST, 100000, divisor loaded into every channel at reset; must fit in CNT_W.
- SCAN_W, 2, width of the scan index advanced by channel 0 ticks.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  N_CH  per-channel run enable; when low the channel holds its count and outputs no ticks.
- sync_clr  in  1  synchronous clear of all channel counters, square outputs and scan index.
- div_wr  in  1  divisor write strobe, one cycle.
- div_ch  in  $clog2(N_CH) (min 1)  channel selected by div_wr.
- div_val  in  CNT_W  new divisor value.
- tick  out  N_CH  single-cycle pulse at the channel's terminal count.
- sq  out  N_CH  toggles on every tick of its channel (period 2*div).
- scan  out  SCAN_W  increments on every channel-0 tick, wraps modulo 2^SCAN_W.
- div_busy  out  N_CH  high while a written divisor is pending and not yet applied.

Behaviour:
- Reset is asynchronous and active-low; the clock is `clk`.
- Reset values:
  - all counters = 0; active and shadow divisors = DIV_RST.
  - tick = 0, sq = 0, scan = 0, div_busy = 0.
- Per channel, with en[i]=1:
  - count increments each cycle.
  - When count == act_div-1: count <= 0, and tick[i] is registered high for exactly that next cycle.
  - sq[i] toggles in the same cycle that tick[i] goes high.
  - Tick-to-tick period is act_div cycles.
- Divisor 0 or 1: behaves as divisor 1, so tick stays high every cycle while enabled and sq toggles every cycle.
- en[i]=0: count, sq and act_div hold; tick[i]=0 from the next cycle. Re-enabling resumes from the held count with no extra tick.
- Divisor write:
  - div_wr loads div_val into shadow[div_ch] and sets div_busy[div_ch] on the next cycle.
  - shadow is copied to act_div at the channel's next terminal count, or on sync_clr, whichever comes first; div_busy clears at that point.
  - Divisor changes therefore never produce a shortened or glitched period.
- div_ch >= N_CH: write ignored, no state change.
- A second write to the same channel while busy overwrites the shadow; only the last value is applied.
- sync_clr has priority over counting and over div_wr in the same cycle, and the div_wr is dropped. On sync_clr:
  - all counts = 0, sq = 0, scan = 0, tick = 0.
  - pending shadows are applied.
- scan: registered; increments by 1 in the cycle tick[0] goes high and wraps from 2^SCAN_W-1 to 0.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Count comparison uses full CNT_W width; there is no overflow because count < act_div <= 2^CNT_W-1.
- Reset asserted mid-period: all state is returned to reset values immediately. After deassertion the first tick arrives DIV_RST cycles later (with en high).

Decomposition:
- Shared package tick_pkg holds:
  - the DIV_RST default constant;
  - a typedef for the divisor word, `div_t` = logic [CNT_W-1:0];
  - a helper function clamping divisors of 0 to 1.
- Natural sub-module tick_channel: one counter, shadow/active divisor, tick, sq and busy. It is instantiated N_CH times by a generate loop.
- The top level holds the write decode, sync_clr fan-out and the scan counter.

Test Plan:
- Default divisor: reset, en=all ones, DIV_RST overridden to 4 → tick[i] high on cycles 4, 8, 12 after reset release; sq toggles each tick; scan counts 1, 2, 3, 0.
- Mid-period divisor change: div=10 running, write div_val=3 to ch1 at count 2 → div_busy[1]=1; next tick at original count 9, then ticks every 3 cycles; busy clears at the switch.
- Enable pause: en[2]=0 for 7 cycles at count 5 of div=8 → no tick during pause; first tick 3 cycles after re-enable.
- sync_clr collision: sync_clr and div_wr to ch0 in the same cycle → all counts, sq and scan are 0 next cycle; written value not applied; prior pending shadow applied.
- Edge divisors: div_val 0 and 1 → tick continuously high, sq toggling every cycle. Write with div_ch=N_CH → no change, div_busy stays 0.
- Async reset: assert rst_n low mid-count without a clock edge → outputs are 0 immediately and divisors return to DIV_RST.
